// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// Arbitration policy is selected in arb_rr2 by MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_LSU   = 1'b1
  } port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rsp_t;

  // Maps a one-hot grant to the port it selects; an idle grant maps to PORT_FETCH.
  function automatic port_id_t gnt_to_port(input logic [1:0] gnt);
    return gnt[1] ? PORT_LSU : PORT_FETCH;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-input arbiter with one-hot grant.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority with port 1 winning.
module arb_rr2
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_id_t last_q, last_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= PORT_LSU;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On conflict the port that was not served most recently wins.
      2'b11:   gnt = (last_q == PORT_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (gnt != 2'b00) begin
      last_d = gnt_to_port(gnt);
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:        gnt = 2'b01;
      2'b10, 2'b11: gnt = 2'b10;
      default:      gnt = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port RAM between instruction fetch (port 0) and load/store (port 1).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 1).
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0] req_vec;
  logic [1:0] gnt;
  rsp_t       rsp_q, rsp_d;
  logic       rsp_live;

  // Requests are masked during reset so no grant and no pointer movement can occur.
  assign req_vec = {p1_req, p0_req} & {2{rst_n}};

  arb_rr2 u_arb (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req   (req_vec),
    .gnt   (gnt)
  );

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (gnt)
      2'b01: begin
        ram_wr_en = p0_we;
        ram_addr  = p0_addr;
        ram_wdata = p0_we ? p0_wdata : '0;
      end
      2'b10: begin
        ram_wr_en = p1_we;
        ram_addr  = p1_addr;
        ram_wdata = p1_we ? p1_wdata : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_d       = '{valid: 1'b0, port: PORT_FETCH};
    rsp_d.valid = (gnt != 2'b00) && !ram_wr_en;
    rsp_d.port  = gnt_to_port(gnt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_q <= '{valid: 1'b0, port: PORT_FETCH};
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Gating with rst_n keeps both response ports quiet for the whole reset window.
  assign rsp_live  = rsp_q.valid && rst_n;
  assign p0_rvalid = rsp_live && (rsp_q.port == PORT_FETCH);
  assign p1_rvalid = rsp_live && (rsp_q.port == PORT_LSU);
  assign p0_rdata  = p0_rvalid ? ram_rdata : '0;
  assign p1_rdata  = p1_rvalid ? ram_rdata : '0;

  a_gnt_excl: assert property (@(posedge clk) !(p0_gnt && p1_gnt));
  a_gnt0_req: assert property (@(posedge clk) p0_gnt |-> p0_req);
  a_gnt1_req: assert property (@(posedge clk) p1_gnt |-> p1_req);
  a_rv_excl:  assert property (@(posedge clk) !(p0_rvalid && p1_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector table and
// randomized traffic checked against a grant/scoreboard model and a shadow memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .ram_wr_en (ram_wr_en),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h0800_0020 : ((32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  // RAM model: write or registered read at each rising edge.
  logic [31:0] ram [1024];
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_wr_en) ram[ram_addr] <= ram_wdata;
      else           ram_rdata     <= ram[ram_addr];
    end
  end

  // Reference state: shadow memory, last-served port and the response due next cycle.
  logic [31:0] ref_mem [1024];
  int          last_srv;
  bit          exp_valid;
  int          exp_port;
  logic [31:0] exp_data;
  int          pend_g, granted;
  logic        pend_we;
  logic [9:0]  pend_addr;
  logic [31:0] pend_wd;
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic set_ports(input logic r0, input logic w0, input logic [9:0] a0,
                           input logic [31:0] d0, input logic r1, input logic w1,
                           input logic [9:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Checks all outputs at the falling edge against the model's prediction.
  task automatic check_cycle();
    bit r0, r1, v0, v1;
    @(negedge clk);
    r0 = p0_req && rst_n;
    r1 = p1_req && rst_n;
    if (r0 && r1) pend_g = RR ? ((last_srv == 0) ? 1 : 0) : 1;
    else if (r0)  pend_g = 0;
    else if (r1)  pend_g = 1;
    else          pend_g = -1;
    pend_we   = (pend_g == 0) ? p0_we    : (pend_g == 1) ? p1_we    : 1'b0;
    pend_addr = (pend_g == 0) ? p0_addr  : (pend_g == 1) ? p1_addr  : 10'd0;
    pend_wd   = (pend_g == 0) ? p0_wdata : (pend_g == 1) ? p1_wdata : 32'd0;
    chk("p0_gnt", 32'(p0_gnt), 32'(pend_g == 0));
    chk("p1_gnt", 32'(p1_gnt), 32'(pend_g == 1));
    chk("ram_wr_en", 32'(ram_wr_en), 32'(pend_we));
    chk("ram_addr", 32'(ram_addr), 32'(pend_addr));
    chk("ram_wdata", ram_wdata, pend_we ? pend_wd : 32'd0);
    v0 = exp_valid && rst_n && (exp_port == 0);
    v1 = exp_valid && rst_n && (exp_port == 1);
    chk("p0_rvalid", 32'(p0_rvalid), 32'(v0));
    chk("p1_rvalid", 32'(p1_rvalid), 32'(v1));
    chk("p0_rdata", p0_rdata, v0 ? exp_data : 32'd0);
    chk("p1_rdata", p1_rdata, v1 ? exp_data : 32'd0);
  endtask

  // Advances the model across the rising edge, then steps to the drive point.
  task automatic commit_cycle();
    @(posedge clk);
    exp_valid = 1'b0;
    granted   = -1;
    if (!rst_n) begin
      last_srv = 1;
    end else if (pend_g >= 0) begin
      granted  = pend_g;
      last_srv = pend_g;
      if (pend_we) begin
        ref_mem[pend_addr] = pend_wd;
      end else begin
        exp_valid = 1'b1;
        exp_port  = pend_g;
        exp_data  = ref_mem[pend_addr];
      end
    end
    #1;
  endtask

  task automatic cycle();
    check_cycle();
    commit_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       r0, w0;
    logic [9:0] a0;
    logic [31:0] d0;
    logic       r1, w1;
    logic [9:0] a1;
    logic [31:0] d1;
    logic [1:0] g_rr, g_fx;
    logic [9:0] addr_rr, addr_fx;
  } vec_t;

  vec_t tbl [8];
  int   rv0, rv1, idx0, idx1;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    last_srv  = 1;
    exp_valid = 1'b0;
    exp_port  = 0;
    exp_data  = '0;
    granted   = -1;

    // Reset held with both ports requesting.
    rst_n = 1'b0;
    set_ports(1'b1, 1'b0, 10'h011, 32'h0, 1'b1, 1'b0, 10'h022, 32'h0);
    cycle();
    check_cycle();
    chk("rst_no_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    commit_cycle();
    rst_n = 1'b1;
    check_cycle();
    chk("rst_release_p0_gnt", 32'(p0_gnt), 32'(RR));
    chk("rst_release_p1_gnt", 32'(p1_gnt), 32'(!RR));
    commit_cycle();
    set_ports(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();

    // Single read of preloaded word 0 by port 0.
    do_reset();
    set_ports(1'b1, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    p0_req = 1'b0;
    check_cycle();
    chk("single_rd_rvalid", 32'(p0_rvalid), 32'd1);
    chk("single_rd_rdata", p0_rdata, 32'h0800_0020);
    chk("single_rd_p1_rvalid", 32'(p1_rvalid), 32'd0);
    commit_cycle();

    // Port 1 write of the top word, then read-back on the next cycle.
    set_ports(1'b0, 1'b0, 10'h0, 32'h0, 1'b1, 1'b1, 10'h3FF, 32'hDEAD_BEEF);
    cycle();
    p1_we = 1'b0;
    check_cycle();
    chk("wr_no_rvalid", 32'(p1_rvalid), 32'd0);
    commit_cycle();
    p1_req = 1'b0;
    check_cycle();
    chk("rd_after_wr_rdata", p1_rdata, 32'hDEAD_BEEF);
    commit_cycle();

    // Continuous contention for 8 cycles, then port 1 backs off.
    do_reset();
    rv0 = 0; rv1 = 0; idx0 = 0; idx1 = 0;
    for (int i = 0; i < 9; i++) begin
      set_ports(1'b1, 1'b0, 10'(32'h20 + idx0), 32'h0,
                (i < 8), 1'b0, 10'(32'h30 + idx1), 32'h0);
      check_cycle();
      rv0 += int'(p0_rvalid);
      rv1 += int'(p1_rvalid);
      if (i < 8) chk("cont_p0_gnt", 32'(p0_gnt), 32'(RR && (i % 2 == 0)));
      else       chk("cont_p0_gnt_after_drop", 32'(p0_gnt), 32'd1);
      commit_cycle();
      if (granted == 0) idx0++;
      if (granted == 1) idx1++;
    end
    chk("cont_p0_rvalids", 32'(rv0), RR ? 32'd4 : 32'd0);
    chk("cont_p1_rvalids", 32'(rv1), RR ? 32'd4 : 32'd8);
    set_ports(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();

    // Reset arriving right after a granted read.
    do_reset();
    set_ports(1'b1, 1'b0, 10'h010, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    check_cycle();
    chk("midrst_gnt", 32'(p0_gnt), 32'd1);
    rst_n = 1'b0;
    commit_cycle();
    check_cycle();
    chk("midrst_no_rvalid", 32'(p0_rvalid), 32'd0);
    chk("midrst_rdata", p0_rdata, 32'd0);
    commit_cycle();
    rst_n  = 1'b1;
    p0_req = 1'b0;
    check_cycle();
    chk("midrst_cleared", 32'(p0_rvalid), 32'd0);
    commit_cycle();

    // Vector table applied from a fresh reset.
    tbl[0] = '{0, 0, 10'h000, 32'h0, 0, 0, 10'h000, 32'h0, 2'b00, 2'b00, 10'h000, 10'h000};
    tbl[1] = '{1, 0, 10'h005, 32'h0, 0, 0, 10'h000, 32'h0, 2'b01, 2'b01, 10'h005, 10'h005};
    tbl[2] = '{0, 0, 10'h000, 32'h0, 1, 1, 10'h007, 32'hA5A5_0001,
               2'b10, 2'b10, 10'h007, 10'h007};
    tbl[3] = '{1, 0, 10'h001, 32'h0, 1, 0, 10'h002, 32'h0, 2'b01, 2'b10, 10'h001, 10'h002};
    tbl[4] = '{1, 0, 10'h001, 32'h0, 1, 0, 10'h002, 32'h0, 2'b10, 2'b10, 10'h002, 10'h002};
    tbl[5] = '{1, 1, 10'h003, 32'h1234_5678, 1, 0, 10'h004, 32'h0,
               2'b01, 2'b10, 10'h003, 10'h004};
    tbl[6] = '{0, 0, 10'h000, 32'h0, 1, 0, 10'h006, 32'h0, 2'b10, 2'b10, 10'h006, 10'h006};
    tbl[7] = '{1, 0, 10'h008, 32'h0, 1, 0, 10'h009, 32'h0, 2'b01, 2'b10, 10'h008, 10'h009};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_ports(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      check_cycle();
      chk($sformatf("tbl%0d_gnt", i), 32'({p1_gnt, p0_gnt}),
          32'(RR ? tbl[i].g_rr : tbl[i].g_fx));
      chk($sformatf("tbl%0d_addr", i), 32'(ram_addr),
          32'(RR ? tbl[i].addr_rr : tbl[i].addr_fx));
      commit_cycle();
    end
    set_ports(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();

    // Randomized traffic: each requester holds its request until granted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!p0_req && $urandom_range(2) != 0) begin
        p0_req   = 1'b1;
        p0_we    = ($urandom_range(2) == 0);
        p0_addr  = 10'($urandom_range(15));
        p0_wdata = $urandom;
      end
      if (!p1_req && $urandom_range(2) != 0) begin
        p1_req   = 1'b1;
        p1_we    = ($urandom_range(2) == 0);
        p1_addr  = 10'($urandom_range(15));
        p1_wdata = $urandom;
      end
      cycle();
      if (granted == 0) p0_req = 1'b0;
      if (granted == 1) p1_req = 1'b0;
    end
    set_ports(1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
